// File: rtl/rot_load_pkg.sv
// rot_load_pkg: shared types and defaults for the rotate-load controller.
//   state_t   : controller FSM states (IDLE, LOAD, ROTATE, DONE)
//   DEF_WIDTH : default data width of the downstream shifter
//   DEF_DEPTH : default job FIFO depth (power of two, >= 2)
//   ROT_W     : width of the rotation count carried with each job
package rot_load_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROTATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int ROT_W     = 3;

endpackage

// File: rtl/rot_load_fifo.sv
// rot_load_fifo: synchronous FIFO holding {rot, data} jobs.
//   clk, rstn  : clock, synchronous active-low reset
//   push/wdata : write request (ignored while full)
//   pop/rdata  : read request (ignored while empty); rdata shows the head
//   full/empty : occupancy flags, derived from registered level only
//   level      : current occupancy, 0..DEPTH
module rot_load_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push_ok, pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rstn && push_ok) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rot_load_ctrl.sv
// rot_load_ctrl: queues {byte, rotation} jobs and drives a downstream
// left-rotate shift register. Each job is loaded with a one-cycle load_en,
// then the shifter free-runs (rotl by 1 per cycle) for rot cycles, after
// which done pulses: the shifter then holds rotl(data, rot).
//   clk, rstn          : clock, synchronous active-low reset
//   in_valid/in_ready  : job handshake; in_ready depends on FIFO level only
//   in_data, in_rot    : job payload
//   load_val, load_en  : parallel load to the shifter
//   done               : one-cycle completion pulse
//   busy               : FSM outside IDLE
//   level              : FIFO occupancy
module rot_load_ctrl
  import rot_load_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [ROT_W-1:0]       in_rot,
  output logic [WIDTH-1:0]       load_val,
  output logic                   load_en,
  output logic                   done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int FW = WIDTH + ROT_W;

  state_t           state;
  logic [ROT_W-1:0] cnt;
  logic [FW-1:0]    head;
  logic             full, empty, pop;

  assign in_ready = !full;
  // Pop only from IDLE; state and empty are both registered, so no
  // combinational path exists from in_valid to in_ready or pop.
  assign pop = (state == IDLE) && !empty;

  rot_load_fifo #(
    .DW    (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (in_valid),
    .wdata ({in_rot, in_data}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Outputs are registered alongside the state so load_en/done/busy line
  // up exactly with LOAD/DONE/non-IDLE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      load_val <= '0;
      load_en  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      load_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            load_val <= head[WIDTH-1:0];
            cnt      <= head[FW-1:WIDTH];
            state    <= LOAD;
            load_en  <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (cnt != '0) begin
            state <= ROTATE;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        ROTATE: begin
          // Leaving on cnt==1 makes ROTATE last exactly rot cycles.
          cnt <= cnt - 1'b1;
          if (cnt == ROT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
